// File: rtl/dm_access_ctrl_if.sv
// Bus bundle between the M stage, the DMA port, the memory and dm_access_ctrl.
// slave = the access controller's view, master = the surrounding environment.
interface dm_access_ctrl_if;
  // M-stage request / response
  logic        m_req;
  logic        m_we;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_stall;
  logic        m_done;
  logic [31:0] m_rdata;
  logic        m_align_err;
  // DMA request / response
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_timeout;
  // memory side
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  m_req, m_we, m_size, m_addr, m_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ack,
    output m_stall, m_done, m_rdata, m_align_err,
    output d_done, d_rdata, d_timeout,
    output mem_req, mem_addr, mem_byteen, mem_wdata
  );

  modport master (
    output m_req, m_we, m_size, m_addr, m_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ack,
    input  m_stall, m_done, m_rdata, m_align_err,
    input  d_done, d_rdata, d_timeout,
    input  mem_req, mem_addr, mem_byteen, mem_wdata
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: round-robin arbitration between the M stage
// and a DMA port onto a single-outstanding memory bus, with store lane
// steering, load sign extension, misalignment trapping and a BUSY timeout.
module dm_access_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input logic            clk,
  input logic            reset,
  dm_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic       OWN_M     = 1'b0;
  localparam logic       OWN_D     = 1'b1;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e      state_q;
  logic        owner_q;
  logic        last_owner_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [7:0]  cnt_q;
  logic        mem_req_q;
  logic [3:0]  mem_byteen_q;
  logic [31:0] mem_wdata_q;
  logic        m_done_q;
  logic        m_err_q;
  logic [31:0] m_rdata_q;
  logic        d_done_q;
  logic        d_to_q;
  logic [31:0] d_rdata_q;

  logic        grant_d;
  logic        we_d;
  logic [1:0]  size_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic        misalign_d;
  logic [3:0]  be_d;
  logic [31:0] mwd_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_d;

  // Winner selection and request muxing; DMA is always a full word.
  always_comb begin
    grant_d = OWN_M;
    if (bus.m_req && bus.d_req) grant_d = ~last_owner_q;
    else if (bus.d_req)         grant_d = OWN_D;

    we_d    = grant_d ? bus.d_we    : bus.m_we;
    size_d  = grant_d ? 2'b10       : bus.m_size;
    addr_d  = grant_d ? bus.d_addr  : bus.m_addr;
    wdata_d = grant_d ? bus.d_wdata : bus.m_wdata;

    misalign_d = (grant_d == OWN_M) &&
                 (((bus.m_size == 2'b01) && bus.m_addr[0]) ||
                  (bus.m_size[1] && (bus.m_addr[1:0] != 2'b00)));

    be_d = 4'b0000;
    if (we_d) begin
      case (size_d)
        2'b00:   be_d = 4'b0001 << addr_d[1:0];
        2'b01:   be_d = addr_d[1] ? 4'b1100 : 4'b0011;
        default: be_d = 4'b1111;
      endcase
    end

    case (size_d)
      2'b00:   mwd_d = {4{wdata_d[7:0]}};
      2'b01:   mwd_d = {2{wdata_d[15:0]}};
      default: mwd_d = wdata_d;
    endcase
  end

  // Load lane extraction for M; DMA data passes through untouched.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = bus.mem_rdata[7:0];
      2'b01:   ld_byte = bus.mem_rdata[15:8];
      2'b10:   ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_d = {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_d = {{16{ld_half[15]}}, ld_half};
      default: ld_d = bus.mem_rdata;
    endcase
    if (owner_q == OWN_D) ld_d = bus.mem_rdata;
  end

  // Access FSM with all bus/response outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_M;
      last_owner_q <= OWN_D;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_byteen_q <= 4'b0000;
      mem_wdata_q  <= '0;
      m_done_q     <= 1'b0;
      m_err_q      <= 1'b0;
      m_rdata_q    <= '0;
      d_done_q     <= 1'b0;
      d_to_q       <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      // done/error are single-cycle pulses raised only on entry to RESP
      m_done_q <= 1'b0;
      m_err_q  <= 1'b0;
      d_done_q <= 1'b0;
      d_to_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.m_req || bus.d_req) begin
            owner_q      <= grant_d;
            last_owner_q <= grant_d;
            we_q         <= we_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            cnt_q        <= '0;
            if (misalign_d) begin
              // trapped without touching memory
              state_q   <= RESP;
              m_done_q  <= 1'b1;
              m_err_q   <= 1'b1;
              m_rdata_q <= '0;
            end else begin
              state_q      <= BUSY;
              mem_req_q    <= 1'b1;
              mem_byteen_q <= be_d;
              mem_wdata_q  <= mwd_d;
            end
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            state_q      <= RESP;
            mem_req_q    <= 1'b0;
            mem_byteen_q <= 4'b0000;
            if (owner_q == OWN_D) begin
              d_done_q <= 1'b1;
              if (!we_q) d_rdata_q <= ld_d;
            end else begin
              m_done_q <= 1'b1;
              if (!we_q) m_rdata_q <= ld_d;
            end
          end else if (cnt_q == WAIT_LAST) begin
            // this cycle would be the MAX_WAIT-th without ack: give up
            state_q      <= RESP;
            mem_req_q    <= 1'b0;
            mem_byteen_q <= 4'b0000;
            if (owner_q == OWN_D) begin
              d_done_q  <= 1'b1;
              d_to_q    <= 1'b1;
              d_rdata_q <= '0;
            end else begin
              m_done_q  <= 1'b1;
              m_err_q   <= 1'b1;
              m_rdata_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m_stall     = bus.m_req & ~m_done_q;
  assign bus.m_done      = m_done_q;
  assign bus.m_rdata     = m_rdata_q;
  assign bus.m_align_err = m_err_q;
  assign bus.d_done      = d_done_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.d_timeout   = d_to_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = {addr_q[31:2], 2'b00};
  assign bus.mem_byteen  = mem_byteen_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: inputs driven and outputs sampled on the
// falling clock edge; expected values are hand-computed constants.
module tb_dm_access_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_access_ctrl_if bus();

  dm_access_ctrl #(.MAX_WAIT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  typedef struct {
    bit          dma;
    bit          we;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;   // BUSY cycles before ack; 255 = never ack
    bit          mem;   // expect a memory request
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] ma;
    logic [31:0] rdx;
    bit          ckrd;
    bit          err;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] arb_a[4] = '{32'h80, 32'h40, 32'h84, 32'h44};
  bit          arb_d[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  // Issue one request, ack after t.dly BUSY cycles, collect the response.
  task automatic xfer(input vec_t t, output logic [31:0] rd_o, output logic err_o,
                      output logic [3:0] be_o, output logic [31:0] mwd_o,
                      output logic [31:0] ma_o, output int nbusy, output int lat,
                      output bit stable);
    bit done;
    done = 0; rd_o = '0; err_o = 0; be_o = '0; mwd_o = '0; ma_o = '0;
    nbusy = 0; lat = 0; stable = 1;
    if (t.dma) begin
      bus.d_req = 1; bus.d_we = t.we; bus.d_addr = t.a; bus.d_wdata = t.wd;
    end else begin
      bus.m_req = 1; bus.m_we = t.we; bus.m_size = t.sz; bus.m_addr = t.a; bus.m_wdata = t.wd;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      lat++;
      bus.mem_ack = 0;
      if (t.dma ? bus.d_done : bus.m_done) begin
        done  = 1;
        rd_o  = t.dma ? bus.d_rdata : bus.m_rdata;
        err_o = t.dma ? bus.d_timeout : bus.m_align_err;
      end else if (bus.mem_req) begin
        if (nbusy == 0) begin
          be_o = bus.mem_byteen; mwd_o = bus.mem_wdata; ma_o = bus.mem_addr;
        end else if (be_o !== bus.mem_byteen || mwd_o !== bus.mem_wdata || ma_o !== bus.mem_addr) begin
          stable = 0;
        end
        if (nbusy == t.dly) begin
          bus.mem_ack = 1; bus.mem_rdata = t.rd;
        end
        nbusy++;
      end
    end
    bus.m_req = 0; bus.d_req = 0; bus.mem_ack = 0;
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] rd_o, mwd_o, ma_o;
    logic        err_o;
    logic [3:0]  be_o;
    int          nbusy, lat, w, exp_busy;
    bit          stable;

    bus.m_req = 0; bus.m_we = 0; bus.m_size = 0; bus.m_addr = 0; bus.m_wdata = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.mem_rdata = 0; bus.mem_ack = 0;
    reset = 1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_byteen",  32'(bus.mem_byteen), 0);
    chk("rst_m_done",  32'(bus.m_done), 0);
    chk("rst_d_done",  32'(bus.d_done), 0);
    chk("rst_errs",    32'({bus.m_align_err, bus.d_timeout}), 0);
    chk("rst_m_rdata", bus.m_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_stall",   32'(bus.m_stall), 0);
    reset = 0;
    @(negedge clk);

    // stray ack in IDLE is ignored
    bus.mem_ack = 1;
    @(negedge clk);
    bus.mem_ack = 0;
    chk("idle_ack_m_done", 32'(bus.m_done), 0);
    chk("idle_ack_d_done", 32'(bus.d_done), 0);
    chk("idle_ack_mreq",   32'(bus.mem_req), 0);

    // sb 0x1003 with ack in first BUSY cycle: cycle-exact
    bus.m_req = 1; bus.m_we = 1; bus.m_size = 2'b00; bus.m_addr = 32'h1003; bus.m_wdata = 32'hAB;
    #1;
    chk("sb_c0_stall", 32'(bus.m_stall), 1);
    chk("sb_c0_mreq",  32'(bus.mem_req), 0);
    @(negedge clk);
    chk("sb_c1_mreq",   32'(bus.mem_req), 1);
    chk("sb_c1_byteen", 32'(bus.mem_byteen), 32'b1000);
    chk("sb_c1_wdata",  bus.mem_wdata, 32'hABABABAB);
    chk("sb_c1_addr",   bus.mem_addr, 32'h1000);
    chk("sb_c1_stall",  32'(bus.m_stall), 1);
    chk("sb_c1_done",   32'(bus.m_done), 0);
    bus.mem_ack = 1;
    @(negedge clk);
    bus.mem_ack = 0;
    chk("sb_c2_done",  32'(bus.m_done), 1);
    chk("sb_c2_err",   32'(bus.m_align_err), 0);
    chk("sb_c2_stall", 32'(bus.m_stall), 0);
    chk("sb_c2_mreq",  32'(bus.mem_req), 0);
    bus.m_req = 0;
    @(negedge clk);
    chk("sb_c3_done", 32'(bus.m_done), 0);

    // dma we sz  addr          wdata         rdata       dly mem be     mwd           maddr         rdata exp    ck err
    vecs.push_back('{0,0,2'b01,32'h2002,32'h0,       32'h80011234,3,  1,4'b0000,32'h0,       32'h2000,32'hFFFF8001,1,0});
    vecs.push_back('{0,1,2'b00,32'h1001,32'h5A,      32'h0,       0,  1,4'b0010,32'h5A5A5A5A,32'h1000,32'h0,       0,0});
    vecs.push_back('{0,1,2'b01,32'h1002,32'hBEEF1234,32'h0,       1,  1,4'b1100,32'h12341234,32'h1000,32'h0,       0,0});
    vecs.push_back('{0,1,2'b01,32'h1000,32'h0000ABCD,32'h0,       0,  1,4'b0011,32'hABCDABCD,32'h1000,32'h0,       0,0});
    vecs.push_back('{0,1,2'b10,32'h1008,32'hCAFEF00D,32'h0,       2,  1,4'b1111,32'hCAFEF00D,32'h1008,32'h0,       0,0});
    vecs.push_back('{0,1,2'b11,32'h100C,32'h01234567,32'h0,       0,  1,4'b1111,32'h01234567,32'h100C,32'h0,       0,0});
    vecs.push_back('{0,0,2'b00,32'h1001,32'h0,       32'h12348056,0,  1,4'b0000,32'h0,       32'h1000,32'hFFFFFF80,1,0});
    vecs.push_back('{0,0,2'b00,32'h1002,32'h0,       32'h127F0000,0,  1,4'b0000,32'h0,       32'h1000,32'h0000007F,1,0});
    vecs.push_back('{0,0,2'b01,32'h1000,32'h0,       32'h80017FFE,0,  1,4'b0000,32'h0,       32'h1000,32'h00007FFE,1,0});
    vecs.push_back('{0,0,2'b10,32'h1004,32'h0,       32'h89ABCDEF,0,  1,4'b0000,32'h0,       32'h1004,32'h89ABCDEF,1,0});
    vecs.push_back('{0,0,2'b00,32'h1003,32'h0,       32'h80FFFFFF,1,  1,4'b0000,32'h0,       32'h1000,32'hFFFFFF80,1,0});
    vecs.push_back('{0,0,2'b10,32'h0006,32'h0,       32'h0,       0,  0,4'b0000,32'h0,       32'h0,   32'h0,       1,1});
    vecs.push_back('{0,1,2'b01,32'h1001,32'h0,       32'h0,       0,  0,4'b0000,32'h0,       32'h0,   32'h0,       1,1});
    vecs.push_back('{1,1,2'b00,32'h1006,32'h01020304,32'h0,       0,  1,4'b1111,32'h01020304,32'h1004,32'h0,       0,0});
    vecs.push_back('{1,0,2'b00,32'h2000,32'h0,       32'hDEADBEEF,1,  1,4'b0000,32'hDEADBEEF & 32'h0,32'h2000,32'hDEADBEEF,1,0});
    vecs.push_back('{1,0,2'b00,32'h3000,32'h0,       32'h0,       255,1,4'b0000,32'h0,       32'h3000,32'h0,       1,1});

    foreach (vecs[i]) begin
      xfer(vecs[i], rd_o, err_o, be_o, mwd_o, ma_o, nbusy, lat, stable);
      exp_busy = !vecs[i].mem ? 0 : (vecs[i].dly == 255 ? 15 : vecs[i].dly + 1);
      chk($sformatf("v%0d_nbusy", i), 32'(nbusy), 32'(exp_busy));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(exp_busy + 1));
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].err));
      chk($sformatf("v%0d_mreq_done", i), 32'(bus.mem_req), 0);
      if (vecs[i].mem) begin
        chk($sformatf("v%0d_be", i), 32'(be_o), 32'(vecs[i].be));
        chk($sformatf("v%0d_mwd", i), mwd_o, vecs[i].mwd);
        chk($sformatf("v%0d_maddr", i), ma_o, vecs[i].ma);
        chk($sformatf("v%0d_stable", i), 32'(stable), 1);
      end
      if (vecs[i].ckrd) chk($sformatf("v%0d_rdata", i), rd_o, vecs[i].rdx);
      @(negedge clk);
      chk($sformatf("v%0d_done_low", i), 32'({bus.m_done, bus.d_done}), 0);
      chk($sformatf("v%0d_err_low", i), 32'({bus.m_align_err, bus.d_timeout}), 0);
      if (vecs[i].ckrd)
        chk($sformatf("v%0d_rd_hold", i), vecs[i].dma ? bus.d_rdata : bus.m_rdata, vecs[i].rdx);
    end

    // round-robin: after reset M wins first tie, then alternation
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    bus.m_req = 1; bus.m_we = 0; bus.m_size = 2'b10; bus.m_addr = 32'h80;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
    for (int g = 0; g < 4; g++) begin
      w = 0;
      @(negedge clk);
      while (!bus.mem_req && w < 8) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("arb%0d_addr", g), bus.mem_addr, arb_a[g]);
      bus.mem_ack = 1; bus.mem_rdata = 32'h0;
      @(negedge clk);
      bus.mem_ack = 0;
      chk($sformatf("arb%0d_m_done", g), 32'(bus.m_done), 32'(!arb_d[g]));
      chk($sformatf("arb%0d_d_done", g), 32'(bus.d_done), 32'(arb_d[g]));
      if (arb_d[g]) bus.d_addr = bus.d_addr + 32'd4;
      else          bus.m_addr = bus.m_addr + 32'd4;
    end
    bus.m_req = 0; bus.d_req = 0;
    @(negedge clk);

    // reset while a sw is in BUSY aborts it silently
    bus.m_req = 1; bus.m_we = 1; bus.m_size = 2'b10; bus.m_addr = 32'h300; bus.m_wdata = 32'h11223344;
    @(negedge clk);
    chk("rstb_mreq_busy", 32'(bus.mem_req), 1);
    reset = 1;
    @(negedge clk);
    chk("rstb_mreq_low", 32'(bus.mem_req), 0);
    chk("rstb_no_done",  32'(bus.m_done), 0);
    bus.m_req = 0;
    reset = 0;
    @(negedge clk);
    chk("rstb_idle_mreq", 32'(bus.mem_req), 0);
    chk("rstb_idle_done", 32'(bus.m_done), 0);
    xfer('{0,1,2'b10,32'h300,32'h11223344,32'h0,1,1,4'b1111,32'h11223344,32'h300,32'h0,0,0},
         rd_o, err_o, be_o, mwd_o, ma_o, nbusy, lat, stable);
    chk("rstb_sw_lat",   32'(lat), 3);
    chk("rstb_sw_err",   32'(err_o), 0);
    chk("rstb_sw_be",    32'(be_o), 32'b1111);
    chk("rstb_sw_wdata", mwd_o, 32'h11223344);
    chk("rstb_sw_addr",  ma_o, 32'h300);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
